// File: rtl/mux_nx1_seq.sv
// mux_nx1_seq: registered NCH-to-1 channel mux with manual select or round-robin scan.
module mux_nx1_seq #(
    parameter int NCH = 4,
    parameter int W = 1,
    parameter int DWELL = 4,
    localparam int SW = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH*W-1:0] din,
    input  logic [SW-1:0]   sel_in,
    input  logic            sel_load,
    input  logic            mode,
    input  logic            hold,
    output logic [W-1:0]    dout,
    output logic [SW-1:0]   cur_sel,
    output logic            switch_pulse,
    output logic            dout_valid
);
    logic [SW-1:0] sel_q, sel_d, sel_nxt;
    logic [7:0]    dwell_q, dwell_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          pulse_q, pulse_d, valid_q, valid_d;
    logic          load_ok, expire;

    always_comb begin
        load_ok = sel_load && (32'(sel_in) < NCH);
        expire  = dwell_q == 8'(DWELL - 1);
        // wrap explicitly so non-power-of-2 NCH never reaches an unused index
        sel_nxt = (sel_q == SW'(NCH - 1)) ? '0 : sel_q + 1'b1;
        sel_d   = hold ? sel_q : load_ok ? sel_in : (mode && expire) ? sel_nxt : sel_q;
        dwell_d = hold ? dwell_q : (load_ok || !mode || expire) ? 8'd0 : dwell_q + 8'd1;
        dout_d  = hold ? dout_q : din[32'(sel_q)*W +: W];
        valid_d = hold ? valid_q : 1'b1;
        pulse_d = sel_d != sel_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q   <= '0;
            dwell_q <= '0;
            dout_q  <= '0;
            pulse_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            dout_q  <= dout_d;
            pulse_q <= pulse_d;
            valid_q <= valid_d;
        end
    end

    assign dout         = dout_q;
    assign cur_sel      = sel_q;
    assign switch_pulse = pulse_q;
    assign dout_valid   = valid_q;
endmodule

// File: tb/tb_mux_nx1_seq.sv
// tb_mux_nx1_seq: table-driven checks of mux_nx1_seq (NCH=4 and NCH=3, W=8, DWELL=3).
module tb_mux_nx1_seq;
    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] din = '0;
    logic [1:0]  sel_in = '0;
    logic        sel_load = 1'b0, mode = 1'b0, hold = 1'b0;
    logic [7:0]  dout, dout3;
    logic [1:0]  cur_sel, sel3;
    logic        switch_pulse, dout_valid, pulse3, valid3;
    int          n_chk = 0, n_fail = 0;

    localparam logic [31:0] D = 32'h44332211;
    localparam logic [31:0] H = 32'hDDCCBBAA;

    typedef struct {
        logic        rst, ld;
        logic [1:0]  si;
        logic        mode, hold;
        logic [31:0] din;
        logic [7:0]  dout;
        logic [1:0]  sel;
        logic        p, v;
    } vec_t;
    vec_t tv[38];

    mux_nx1_seq #(.NCH(4), .W(8), .DWELL(3)) u_dut (
        .clk(clk), .rst(rst), .din(din), .sel_in(sel_in), .sel_load(sel_load),
        .mode(mode), .hold(hold), .dout(dout), .cur_sel(cur_sel),
        .switch_pulse(switch_pulse), .dout_valid(dout_valid)
    );

    mux_nx1_seq #(.NCH(3), .W(8), .DWELL(3)) u_dut3 (
        .clk(clk), .rst(rst), .din(din[23:0]), .sel_in(sel_in), .sel_load(sel_load),
        .mode(mode), .hold(hold), .dout(dout3), .cur_sel(sel3),
        .switch_pulse(pulse3), .dout_valid(valid3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        tv[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, D, 8'h00, 2'd0, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, D, 8'h11, 2'd0, 1'b0, 1'b1};
        tv[2]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, D, 8'h11, 2'd2, 1'b1, 1'b1};
        tv[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, D, 8'h33, 2'd2, 1'b0, 1'b1};
        tv[4]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, D, 8'h33, 2'd2, 1'b0, 1'b1};
        tv[5]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, D, 8'h33, 2'd0, 1'b1, 1'b1};
        tv[6]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h11, 2'd0, 1'b0, 1'b1};
        tv[7]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h11, 2'd0, 1'b0, 1'b1};
        tv[8]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h11, 2'd1, 1'b1, 1'b1};
        tv[9]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h22, 2'd1, 1'b0, 1'b1};
        tv[10] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h22, 2'd1, 1'b0, 1'b1};
        tv[11] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h22, 2'd2, 1'b1, 1'b1};
        tv[12] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h33, 2'd2, 1'b0, 1'b1};
        tv[13] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h33, 2'd2, 1'b0, 1'b1};
        tv[14] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h33, 2'd3, 1'b1, 1'b1};
        tv[15] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h44, 2'd3, 1'b0, 1'b1};
        tv[16] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h44, 2'd3, 1'b0, 1'b1};
        tv[17] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h44, 2'd0, 1'b1, 1'b1};
        tv[18] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h11, 2'd0, 1'b0, 1'b1};
        tv[19] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h11, 2'd0, 1'b0, 1'b1};
        tv[20] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h11, 2'd1, 1'b1, 1'b1};
        tv[21] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h22, 2'd1, 1'b0, 1'b1};
        tv[22] = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b0, D, 8'h22, 2'd3, 1'b1, 1'b1};
        tv[23] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h44, 2'd3, 1'b0, 1'b1};
        tv[24] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h44, 2'd3, 1'b0, 1'b1};
        tv[25] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h44, 2'd0, 1'b1, 1'b1};
        tv[26] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, D, 8'h11, 2'd0, 1'b0, 1'b1};
        tv[27] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b1, H, 8'h11, 2'd0, 1'b0, 1'b1};
        tv[28] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, H, 8'h11, 2'd0, 1'b0, 1'b1};
        tv[29] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, H, 8'h11, 2'd0, 1'b0, 1'b1};
        tv[30] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, H, 8'h11, 2'd0, 1'b0, 1'b1};
        tv[31] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, H, 8'h11, 2'd0, 1'b0, 1'b1};
        tv[32] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, H, 8'hAA, 2'd0, 1'b0, 1'b1};
        tv[33] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, H, 8'hAA, 2'd1, 1'b1, 1'b1};
        tv[34] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, H, 8'hAA, 2'd1, 1'b0, 1'b1};
        tv[35] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, H, 8'hBB, 2'd1, 1'b0, 1'b1};
        tv[36] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, H, 8'hBB, 2'd1, 1'b0, 1'b1};
        tv[37] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, H, 8'hBB, 2'd2, 1'b1, 1'b1};

        din = D;
        #1 rst = 1'b1;
        #1;
        chk("reset dout", 32'(dout), 32'h0);
        chk("reset valid", 32'(dout_valid), 32'h0);
        chk("reset sel", 32'(cur_sel), 32'h0);

        for (int i = 0; i < 38; i++) begin
            rst = tv[i].rst; sel_load = tv[i].ld; sel_in = tv[i].si;
            mode = tv[i].mode; hold = tv[i].hold; din = tv[i].din;
            @(posedge clk); #1;
            chk($sformatf("row%0d dout", i), 32'(dout), 32'(tv[i].dout));
            chk($sformatf("row%0d sel", i), 32'(cur_sel), 32'(tv[i].sel));
            chk($sformatf("row%0d pulse", i), 32'(switch_pulse), 32'(tv[i].p));
            chk($sformatf("row%0d valid", i), 32'(dout_valid), 32'(tv[i].v));
        end

        // asynchronous reset between edges while channel 2 is selected
        #3 rst = 1'b1;
        #1;
        chk("async sel", 32'(cur_sel), 32'h0);
        chk("async dout", 32'(dout), 32'h0);
        chk("async valid", 32'(dout_valid), 32'h0);
        chk("async pulse", 32'(switch_pulse), 32'h0);
        mode = 1'b0; din = D;
        @(posedge clk); #1;
        chk("held reset valid", 32'(dout_valid), 32'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("release dout", 32'(dout), 32'h11);
        chk("release valid", 32'(dout_valid), 32'h1);
        chk("release dout3", 32'(dout3), 32'h11);
        chk("release valid3", 32'(valid3), 32'h1);

        // NCH=3 instance must ignore the out-of-range index and keep scanning
        mode = 1'b1; sel_load = 1'b1; sel_in = 2'd3;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            chk($sformatf("nch3 step%0d sel", k), 32'(sel3), 32'((k / 3) % 3));
            chk($sformatf("nch3 step%0d pulse", k), 32'(pulse3), 32'(k % 3 == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
